// File: rtl/vmac_pkg.sv
// vmac_pkg: shared state encoding and default geometry for the MAC sequencer and array wrapper
package vmac_pkg;
  localparam int VMAC_REG_WIDTH = 16;
  localparam int VMAC_VECTOR    = 8;
  localparam int VMAC_LEN_W     = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} vmac_state_e;
endpackage

// File: rtl/vector_mac_seq_if.sv
// vector_mac_seq_if: operand and result valid/ready streams of the MAC sequencer
interface vector_mac_seq_if
  import vmac_pkg::*;
#(
  parameter int REG_WIDTH = VMAC_REG_WIDTH,
  parameter int VECTOR    = VMAC_VECTOR
);
  logic                              in_valid;
  logic                              in_ready;
  logic [VECTOR-1:0][REG_WIDTH-1:0]  in_a;
  logic [VECTOR-1:0][REG_WIDTH-1:0]  in_b;
  logic                              out_valid;
  logic                              out_ready;
  logic [VECTOR-1:0][REG_WIDTH-1:0]  out_data;
  modport master (output in_valid, in_a, in_b, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_a, in_b, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/vector_mac_seq.sv
// vector_mac_seq: feeds operand beats into the MAC array and accumulates through its output
module vector_mac_seq
  import vmac_pkg::*;
#(
  parameter int REG_WIDTH = VMAC_REG_WIDTH,
  parameter int VECTOR    = VMAC_VECTOR,
  parameter int LEN_W     = VMAC_LEN_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_start,
  input  logic [LEN_W-1:0]                 cfg_len,
  output logic                             busy,
  output logic                             done,
  vector_mac_seq_if.slave                  s,
  output logic [VECTOR-1:0][REG_WIDTH-1:0] mac_a,
  output logic [VECTOR-1:0][REG_WIDTH-1:0] mac_b,
  output logic [VECTOR-1:0][REG_WIDTH-1:0] mac_c,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0] mac_res
);
  typedef logic [VECTOR-1:0][REG_WIDTH-1:0] vec_t;
  vmac_state_e      state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  vec_t             out_data_q, out_data_d;
  logic             beat;
  assign beat       = state_q == RUN && s.in_valid;
  assign busy       = state_q != IDLE;
  assign s.in_ready = state_q == RUN;
  assign s.out_valid = state_q == OUT;
  assign s.out_data = out_data_q;
  assign done       = state_q == OUT && s.out_ready;
  // A zero product leaves the array holding mac_res, so idle cycles are harmless
  always_comb begin
    mac_a = beat ? s.in_a : '0;
    mac_b = beat ? s.in_b : '0;
    mac_c = beat && first_q ? '0 : mac_res;
  end
  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE: if (cfg_start) begin
        if (cfg_len != '0) begin
          cnt_d   = cfg_len;
          first_d = 1'b1;
          state_d = RUN;
        end else begin
          out_data_d = '0;
          state_d    = OUT;
        end
      end
      RUN: if (beat) begin
        first_d = 1'b0;
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == LEN_W'(1) ? DRAIN : RUN;
      end
      DRAIN: begin
        out_data_d = mac_res;
        state_d    = OUT;
      end
      OUT: state_d = s.out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  // State registers; reset discards any job in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      out_data_q <= out_data_d;
    end
  end
endmodule

// File: tb/tb_vector_mac_seq.sv
// tb_vector_mac_seq: directed table of jobs plus reset and backpressure sequences
module tb_vector_mac_seq;
  import vmac_pkg::*;
  localparam int RW = VMAC_REG_WIDTH;
  localparam int VN = VMAC_VECTOR;
  localparam int LW = VMAC_LEN_W;
  typedef logic [VN-1:0][RW-1:0] vec_t;
  typedef struct {
    int   len;
    vec_t a;
    vec_t b;
    int   gaps;
    bit   poke;
    int   hold;
    vec_t exp_res;
    int   exp_lat;
  } vec_rec_t;
  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [LW-1:0] cfg_len;
  logic          busy;
  logic          done;
  vec_t          mac_a, mac_b, mac_c, mac_res;
  int            total = 0;
  int            bad = 0;
  vec_rec_t      tbl[6];
  vec_t          res;
  int            lat;
  vector_mac_seq_if #(.REG_WIDTH(RW), .VECTOR(VN)) bus ();
  vector_mac_seq #(.REG_WIDTH(RW), .VECTOR(VN), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .busy(busy), .done(done), .s(bus),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_res(mac_res)
  );
  always #5 clk = ~clk;
  // Behavioural MAC array: one-cycle registered a*b+c per lane, wrapping
  always_ff @(posedge clk)
    for (int j = 0; j < VN; j++) mac_res[j] <= mac_a[j] * mac_b[j] + mac_c[j];
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic vec_t splat(input int v);
    vec_t r;
    for (int j = 0; j < VN; j++) r[j] = RW'(v);
    return r;
  endfunction
  function automatic vec_t ramp(input int m);
    vec_t r;
    for (int j = 0; j < VN; j++) r[j] = RW'(m * (j + 1));
    return r;
  endfunction
  task automatic run_job(input vec_rec_t r, output vec_t o, output int l);
    int  issued = 0;
    int  g = r.gaps;
    int  cyc = 1;
    bit  stall;
    bus.in_a  = r.a;
    bus.in_b  = r.b;
    cfg_start = 1'b1;
    cfg_len   = LW'(r.len);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    while (!bus.out_valid && cyc < 100) begin
      stall = issued < r.len && g > 0 && cyc % 2 == 1;
      if (stall) g--;
      bus.in_valid = issued < r.len && !stall;
      if (r.poke && cyc == 2) begin
        cfg_start = 1'b1;
        cfg_len   = '0;
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        if (issued == 0) check("first_mac_c", mac_c, '0);
        issued++;
      end
      @(posedge clk); #1;
      cfg_start    = 1'b0;
      bus.in_valid = 1'b0;
      cyc++;
    end
    l = cyc;
    o = bus.out_data;
  endtask
  task automatic accept(input int hold, input vec_t exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_data", bus.out_data, exp);
      check("hold_valid", bus.out_valid, 1'b1);
      check("hold_done", done, 1'b0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_len = '0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_mac_a", mac_a, '0);
    check("rst_mac_b", mac_b, '0);
    check("rst_out_data", bus.out_data, '0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_a = splat(7);
    bus.in_b = splat(7);
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1'b0);
    check("idle_mac_a", mac_a, '0);
    check("idle_mac_b", mac_b, '0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    tbl[0] = '{len: 1, a: splat(3), b: splat(4), gaps: 0, poke: 0, hold: 0, exp_res: splat(12), exp_lat: 3};
    tbl[1] = '{len: 0, a: splat(9), b: splat(9), gaps: 0, poke: 0, hold: 0, exp_res: '0, exp_lat: 1};
    tbl[2] = '{len: 4, a: ramp(1), b: splat(2), gaps: 0, poke: 0, hold: 0, exp_res: ramp(8), exp_lat: 6};
    tbl[3] = '{len: 4, a: ramp(1), b: splat(2), gaps: 3, poke: 0, hold: 5, exp_res: ramp(8), exp_lat: 9};
    tbl[4] = '{len: 2, a: splat(16'h0100), b: splat(16'h0100), gaps: 0, poke: 0, hold: 0, exp_res: '0, exp_lat: 4};
    tbl[5] = '{len: 4, a: ramp(1), b: splat(2), gaps: 0, poke: 1, hold: 0, exp_res: ramp(8), exp_lat: 6};
    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i], res, lat);
      check($sformatf("job%0d_data", i), res, tbl[i].exp_res);
      check($sformatf("job%0d_latency", i), 128'(lat), 128'(tbl[i].exp_lat));
      accept(tbl[i].hold, tbl[i].exp_res);
    end
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    @(posedge clk); #1;
    bus.in_a = splat(1);
    bus.in_b = splat(1);
    cfg_start = 1'b1;
    cfg_len = LW'(4);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_out_data", bus.out_data, '0);
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_job('{len: 1, a: splat(5), b: splat(5), gaps: 0, poke: 0, hold: 0, exp_res: splat(25), exp_lat: 3}, res, lat);
    check("post_rst_data", res, splat(25));
    check("post_rst_latency", 128'(lat), 128'(3));
    accept(1, splat(25));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
